// File: rtl/tone_synth_if.sv
// Tone synthesiser control/audio bundle: note requests and volume in,
// sample stream and playback status out.
interface tone_synth_if #(
    parameter int NOTES    = 4,
    parameter int NOTE_W   = 2,
    parameter int SAMPLE_W = 4
);
    logic [NOTES-1:0]    note_req;
    logic [1:0]          vol;
    logic [SAMPLE_W-1:0] tono;
    logic                sample_stb;
    logic                busy;
    logic [NOTE_W-1:0]   cur_note;

    // Requester side (game logic / bench).
    modport master (
        output note_req, vol,
        input  tono, sample_stb, busy, cur_note
    );

    // Synthesiser side.
    modport slave (
        input  note_req, vol,
        output tono, sample_stb, busy, cur_note
    );
endinterface

// File: rtl/tone_synth.sv
// Click-free sine tone generator. Picks the lowest-indexed active note
// request, steps a 32-entry sine table at that note's rate using a clock
// enable, and only switches note or stops at a waveform period boundary.
module tone_synth #(
    parameter int NOTES    = 4,
    parameter int NOTE_W   = 2,
    parameter int DIV_W    = 16,
    parameter int SAMPLE_W = 4,
    parameter logic [NOTES*DIV_W-1:0] LIMITS =
        {16'hF92, 16'h1282, 16'h14C8, 16'h1754}
) (
    input  logic        clk50mhz,
    input  logic        reset_button,
    tone_synth_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

    localparam int AMP = (1 << (SAMPLE_W - 1)) - 1;
    localparam logic [SAMPLE_W-1:0]   MID   = SAMPLE_W'(1 << (SAMPLE_W - 1));
    localparam logic signed [SAMPLE_W:0] MID_S = (SAMPLE_W + 1)'(1 << (SAMPLE_W - 1));

    // Quarter-wave sine in 0.16 fixed point (entry 8 is exactly 1.0).
    function automatic logic [16:0] quarter_sin(input logic [3:0] idx);
        logic [16:0] v;
        case (idx)
            4'd0:    v = 17'd0;
            4'd1:    v = 17'd12785;
            4'd2:    v = 17'd25080;
            4'd3:    v = 17'd36410;
            4'd4:    v = 17'd46341;
            4'd5:    v = 17'd54491;
            4'd6:    v = 17'd60547;
            4'd7:    v = 17'd64277;
            default: v = 17'd65536;
        endcase
        return v;
    endfunction

    // Signed deviation from MID: round(AMP * sin(2*pi*k/32)).
    function automatic logic signed [SAMPLE_W:0] sine_dev(input logic [4:0] k);
        logic [3:0]                j;
        logic [3:0]                idx;
        logic [47:0]               prod;
        logic signed [SAMPLE_W:0]  mag;
        j    = k[3:0];
        idx  = (j <= 4'd8) ? j : 4'(5'd16 - {1'b0, j});
        prod = 48'(AMP) * 48'(quarter_sin(idx)) + 48'd32768;
        mag  = $signed({1'b0, prod[16 +: SAMPLE_W]});
        return k[4] ? -mag : mag;
    endfunction

    // Table sample at k attenuated by an arithmetic (flooring) shift.
    function automatic logic [SAMPLE_W-1:0] scale_sample(input logic [4:0] k,
                                                         input logic [1:0] v);
        logic signed [SAMPLE_W:0] sum;
        sum = MID_S + (sine_dev(k) >>> v);
        return sum[SAMPLE_W-1:0];
    endfunction

    // Unpack the per-note step periods.
    logic [DIV_W-1:0] lim_arr [NOTES];
    generate
        for (genvar gi = 0; gi < NOTES; gi++) begin : g_lim
            assign lim_arr[gi] = LIMITS[gi*DIV_W +: DIV_W];
        end
    endgenerate

    state_t              state_reg, state_next;
    logic [DIV_W-1:0]    cnt_reg, cnt_next;
    logic [4:0]          addr_reg, addr_next;
    logic [NOTE_W-1:0]   cur_note_reg, cur_note_next;
    logic [NOTE_W-1:0]   pend_reg, pend_next;
    logic                pend_valid_reg, pend_valid_next;
    logic [SAMPLE_W-1:0] tono_reg, tono_next;
    logic                stb_reg, stb_next;
    logic                busy_reg, busy_next;

    logic [NOTE_W-1:0]   req_idx;
    logic                any_req;
    logic [DIV_W-1:0]    lim_cur;
    logic                step;

    assign any_req = |bus.note_req;
    assign lim_cur = lim_arr[cur_note_reg];
    assign step    = (state_reg != IDLE) && (cnt_reg == lim_cur - DIV_W'(1));

    // Fixed priority: lowest set request bit wins.
    always_comb begin
        req_idx = '0;
        for (int i = NOTES - 1; i >= 0; i--) begin
            if (bus.note_req[i]) req_idx = NOTE_W'(i);
        end
    end

    // Next-state: note selection, period stepping and boundary-only changes.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_reg;
        cur_note_next   = cur_note_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        tono_next       = tono_reg;
        stb_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next        = '0;
                addr_next       = '0;
                tono_next       = MID;
                pend_valid_next = 1'b0;
                if (any_req) begin
                    cur_note_next = req_idx;
                    state_next    = PLAY;
                end
            end
            default: begin
                // PLAY and RELEASE both keep stepping; only the request level
                // decides which of the two we are in.
                if (any_req) begin
                    state_next = PLAY;
                    if (req_idx != cur_note_reg) begin
                        pend_next       = req_idx;
                        pend_valid_next = 1'b1;
                    end else begin
                        pend_valid_next = 1'b0;
                    end
                end else begin
                    state_next = RELEASE;
                end

                if (step) begin
                    cnt_next  = '0;
                    addr_next = addr_reg + 5'd1;
                    stb_next  = 1'b1;
                    tono_next = scale_sample(addr_reg + 5'd1, bus.vol);
                    if (addr_reg == 5'd31) begin
                        if (any_req) begin
                            if (pend_valid_next) cur_note_next = pend_next;
                            pend_valid_next = 1'b0;
                        end else begin
                            // End of the last period: fall silent without a
                            // strobe so IDLE never sees sample_stb.
                            state_next      = IDLE;
                            addr_next       = '0;
                            tono_next       = MID;
                            stb_next        = 1'b0;
                            pend_valid_next = 1'b0;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk50mhz) begin
        if (!reset_button) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            cur_note_reg   <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            tono_reg       <= MID;
            stb_reg        <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            cur_note_reg   <= cur_note_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            tono_reg       <= tono_next;
            stb_reg        <= stb_next;
            busy_reg       <= busy_next;
        end
    end

    assign bus.tono       = tono_reg;
    assign bus.sample_stb = stb_reg;
    assign bus.busy       = busy_reg;
    assign bus.cur_note   = cur_note_reg;

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth with short step periods (L = 4,5,6,7 for notes 0..3).
// Stimulus queues the expected sample for every table step; a monitor
// compares each strobe against the queue head.
module tb_tone_synth;

    logic clk50mhz     = 1'b0;
    logic reset_button = 1'b0;

    tone_synth_if #(.NOTES(4), .NOTE_W(2), .SAMPLE_W(4)) bus ();

    tone_synth #(
        .NOTES(4), .NOTE_W(2), .DIV_W(16), .SAMPLE_W(4),
        .LIMITS({16'd7, 16'd6, 16'd5, 16'd4})
    ) dut (
        .clk50mhz    (clk50mhz),
        .reset_button(reset_button),
        .bus         (bus)
    );

    always #10 clk50mhz = ~clk50mhz;

    typedef struct {
        int tono;
        int note;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_stb = 0;

    // Hand-computed sine table for a 4-bit sample, MID = 8.
    int tbl [32] = '{8, 9, 11, 12, 13, 14, 14, 15, 15, 15, 14, 14, 13, 12, 11, 9,
                     8, 7, 5, 4, 3, 2, 2, 1, 1, 1, 2, 2, 3, 4, 5, 7};

    function automatic int scaled(int t, int v);
        int d;
        int dv;
        d  = t - 8;
        dv = 1 << v;
        if (d >= 0) return 8 + d / dv;
        return 8 - ((-d + dv - 1) / dv);
    endfunction

    task automatic check(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_one(int k, int note, int gap, int v);
        exp_t e;
        e.tono = scaled(tbl[k % 32], v);
        e.note = note;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_steps(int k0, int k1, int note, int gap, int v);
        for (int k = k0; k <= k1; k++) push_one(k, note, gap, v);
    endtask

    task automatic wait_strobes(int n);
        int seen;
        int cycles;
        seen   = 0;
        cycles = 0;
        while (seen < n && cycles < 2000) begin
            @(negedge clk50mhz);
            cycles++;
            if (bus.sample_stb) seen++;
        end
        if (seen < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_strobes: saw %0d strobes, expected %0d", seen, n);
        end
    endtask

    task automatic wait_first(string name, int expv);
        int cycles;
        cycles = 0;
        do begin
            @(negedge clk50mhz);
            cycles++;
        end while (!bus.sample_stb && cycles < 200);
        check(name, cycles, expv);
    endtask

    task automatic wait_idle(string name, int expv);
        int cycles;
        cycles = 0;
        do begin
            @(negedge clk50mhz);
            cycles++;
        end while (bus.busy && cycles < 200);
        check(name, cycles, expv);
    endtask

    // Cycle counter used to measure spacing between strobes.
    always @(posedge clk50mhz) cyc <= cyc + 1;

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk50mhz) begin
        exp_t e;
        if (bus.sample_stb) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe with tono=%0d note=%0d, expected none",
                         bus.tono, bus.cur_note);
            end else begin
                e = exp_q.pop_front();
                $display("step tono=%0d note=%0d", bus.tono, bus.cur_note);
                check("stb_tono", int'(bus.tono), e.tono);
                check("stb_note", int'(bus.cur_note), e.note);
                if (e.gap != 0) check("stb_gap", cyc - last_stb, e.gap);
            end
            last_stb = cyc;
        end
    end

    initial begin
        // Reset held with all requests active.
        bus.note_req = 4'b1111;
        bus.vol      = 2'd0;
        reset_button = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk50mhz);
            check("rst_tono", int'(bus.tono), 8);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_stb", int'(bus.sample_stb), 0);
            check("rst_note", int'(bus.cur_note), 0);
        end
        reset_button = 1'b1;
        bus.note_req = 4'b0000;
        repeat (3) @(negedge clk50mhz);
        check("idle_busy", int'(bus.busy), 0);

        // Single note 0 for a full period, L = 4.
        bus.note_req = 4'b0001;
        push_one(1, 0, 0, 0);
        push_steps(2, 32, 0, 4, 0);
        @(negedge clk50mhz);
        check("play_busy", int'(bus.busy), 1);
        check("play_tono0", int'(bus.tono), 8);
        check("play_note", int'(bus.cur_note), 0);
        wait_first("first_step_lat", 4);
        wait_strobes(31);

        // Release at addr 5: keep stepping to the wrap, then silence.
        push_steps(1, 5, 0, 4, 0);
        wait_strobes(5);
        bus.note_req = 4'b0000;
        push_steps(6, 31, 0, 4, 0);
        wait_strobes(26);
        wait_idle("release_wrap_lat", 4);
        check("release_tono", int'(bus.tono), 8);
        repeat (30) @(negedge clk50mhz);
        check("release_busy", int'(bus.busy), 0);

        // Note 2 (L=6), then request note 0 at addr 10: switch only at wrap.
        bus.note_req = 4'b0100;
        push_one(1, 2, 0, 0);
        push_steps(2, 10, 2, 6, 0);
        @(negedge clk50mhz);
        check("n2_note", int'(bus.cur_note), 2);
        wait_first("n2_first_lat", 6);
        wait_strobes(9);
        bus.note_req = 4'b0011;
        push_steps(11, 31, 2, 6, 0);
        push_one(32, 0, 6, 0);
        push_steps(33, 40, 0, 4, 0);
        wait_strobes(21);
        @(negedge clk50mhz);
        check("pend_hold_note", int'(bus.cur_note), 2);
        wait_strobes(9);

        // Release at addr 15, re-press same note at addr 20: no interruption.
        push_steps(9, 15, 0, 4, 0);
        wait_strobes(7);
        bus.note_req = 4'b0000;
        push_steps(16, 20, 0, 4, 0);
        wait_strobes(5);
        bus.note_req = 4'b0001;
        push_steps(21, 35, 0, 4, 0);
        wait_strobes(15);
        check("repress_busy", int'(bus.busy), 1);
        bus.note_req = 4'b0000;
        push_steps(4, 31, 0, 4, 0);
        wait_strobes(28);
        wait_idle("release2_wrap_lat", 4);

        // Volume shift 2 on note 3 (L=7): peak 9, trough 6.
        bus.vol      = 2'd2;
        bus.note_req = 4'b1000;
        push_one(1, 3, 0, 2);
        push_steps(2, 32, 3, 7, 2);
        @(negedge clk50mhz);
        check("n3_note", int'(bus.cur_note), 3);
        wait_first("n3_first_lat", 7);
        wait_strobes(31);
        push_steps(33, 35, 3, 7, 2);
        wait_strobes(3);
        @(negedge clk50mhz);
        check("vol_tono_addr3", int'(bus.tono), 9);

        // Reset mid-play.
        reset_button = 1'b0;
        @(negedge clk50mhz);
        check("midrst_tono", int'(bus.tono), 8);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_stb", int'(bus.sample_stb), 0);
        check("midrst_note", int'(bus.cur_note), 0);
        reset_button = 1'b1;
        bus.note_req = 4'b0000;
        bus.vol      = 2'd0;
        repeat (20) @(negedge clk50mhz);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
